// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Width of the shared carry-lookahead adder and of the product accumulator.
  localparam int unsigned ACC_W = 16;

  // Width of a step counter that has to count 0 .. w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/if_cla_adder.sv
// Operand/result bundle for the shared carry-lookahead adder.
interface if_cla_adder #(
  parameter int unsigned W = 16
);
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         czero;
  logic [W-1:0] sum;
  logic         cout;

  modport master (output in1, output in2, output czero, input sum, input cout);
  modport slave  (input in1, input in2, input czero, output sum, output cout);
endinterface

// File: rtl/if_multiplier.sv
// Multiplier-side signal set: operand handshake in, product handshake out.
interface if_multiplier #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH:0]   out;
  logic               overflow;
  logic               busy;

  modport master (
    output in_valid, output in1, output in2, output out_ready,
    input in_ready, input out_valid, input out, input overflow, input busy
  );
  modport slave (
    input in_valid, input in1, input in2, input out_ready,
    output in_ready, output out_valid, output out, output overflow, output busy
  );
endinterface

// File: rtl/f_cla_16.sv
// 16-bit adder built from four 4-bit carry-lookahead groups.
module f_cla_16 (
  if_cla_adder.slave cla
);
  localparam int unsigned NumGroups = 4;
  localparam int unsigned GroupW    = 4;

  logic [15:0]          gen;
  logic [15:0]          prop;
  logic [15:0]          carry;
  logic [NumGroups-1:0] grp_gen;
  logic [NumGroups-1:0] grp_prop;
  logic [NumGroups:0]   grp_carry;

  // Bit and group generate/propagate, group carries, then in-group carries and sum.
  always_comb begin
    gen       = cla.in1 & cla.in2;
    prop      = cla.in1 ^ cla.in2;
    grp_gen   = '0;
    grp_prop  = '1;
    carry     = '0;
    grp_carry = '0;
    for (int j = 0; j < NumGroups; j++) begin
      for (int i = 0; i < GroupW; i++) begin
        grp_gen[j]  = gen[GroupW*j+i] | (prop[GroupW*j+i] & grp_gen[j]);
        grp_prop[j] = grp_prop[j] & prop[GroupW*j+i];
      end
    end
    grp_carry[0] = cla.czero;
    for (int j = 0; j < NumGroups; j++) begin
      grp_carry[j+1] = grp_gen[j] | (grp_prop[j] & grp_carry[j]);
    end
    for (int j = 0; j < NumGroups; j++) begin
      carry[GroupW*j] = grp_carry[j];
      for (int i = 0; i < GroupW - 1; i++) begin
        carry[GroupW*j+i+1] = gen[GroupW*j+i] | (prop[GroupW*j+i] & carry[GroupW*j+i]);
      end
    end
  end

  assign cla.sum  = prop ^ carry;
  assign cla.cout = grp_carry[NumGroups];

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative unsigned shift-add multiplier sharing one 16-bit CLA across its steps.
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  if_multiplier.slave  mul_side
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  if (2 * WIDTH != ACC_W) begin : g_bad_width
    $error("seq_shift_add_mul: 2*WIDTH must equal the 16-bit adder width");
  end

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH:0]   out_q, out_d;
  logic               overflow_q, overflow_d;

  if_cla_adder #(.W(ACC_W)) cla_if ();

  f_cla_16 u_cla (
    .cla (cla_if)
  );

  assign cla_if.in1   = acc_q;
  assign cla_if.in2   = mcand_q;
  assign cla_if.czero = 1'b0;

  // Next-state and datapath update for the accept / shift-add / hold sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_d      = out_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (mul_side.in_valid) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mul_side.in1};
          mplier_d = mul_side.in2;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          acc_d = cla_if.sum;
          ovf_d = ovf_q | cla_if.cout;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Stop early once no multiplier bits remain to be consumed.
        if ((mplier_q >> 1) == '0 || cnt_q == CntW'(WIDTH - 1)) begin
          state_d    = StDone;
          out_d      = {1'b0, acc_d};
          overflow_d = ovf_d;
        end
      end
      StDone: begin
        if (mul_side.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign mul_side.in_ready  = (state_q == StIdle) && !rst;
  assign mul_side.out_valid = (state_q == StDone);
  assign mul_side.busy      = (state_q != StIdle);
  assign mul_side.out       = out_q;
  assign mul_side.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench: directed operations plus an arithmetic reference model.
module tb_seq_shift_add_mul;

  logic clk;
  logic rst;

  if_multiplier #(.WIDTH(8)) mul_if ();

  seq_shift_add_mul #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mul_side (mul_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model: expected product and number of shift-add steps per accepted pair.
  typedef struct {
    logic [16:0] prod;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  bit   prev_rst = 1'b0;
  bit   first_ov = 1'b1;
  int   run_cnt  = 0;

  function automatic int steps_for(input logic [7:0] b);
    return (b == 0) ? 1 : $clog2(int'(b) + 1);
  endfunction

  // Compare process: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      chk("reset_out_valid", mul_if.out_valid, 0);
      chk("reset_busy", mul_if.busy, 0);
      chk("reset_out", mul_if.out, 0);
      chk("reset_overflow", mul_if.overflow, 0);
    end
    if (rst) begin
      exp_q.delete();
      first_ov = 1'b1;
      run_cnt  = 0;
      chk("in_ready_in_reset", mul_if.in_ready, 0);
    end else begin
      chk("ready_while_busy", mul_if.in_ready && mul_if.busy, 0);
      if (mul_if.out_valid) begin
        chk("result_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          if (first_ov) chk("model_steps", run_cnt, exp_q[0].k);
          first_ov = 1'b0;
          chk("model_product", mul_if.out, exp_q[0].prod);
          chk("model_overflow", mul_if.overflow, 0);
          chk("model_out_msb", mul_if.out[16], 0);
          if (mul_if.out_ready) begin
            void'(exp_q.pop_front());
            first_ov = 1'b1;
          end
        end
      end else if (mul_if.busy) begin
        run_cnt++;
      end
      if (mul_if.in_valid && mul_if.in_ready) begin
        e.prod = 17'(mul_if.in1) * 17'(mul_if.in2);
        e.k    = steps_for(mul_if.in2);
        exp_q.push_back(e);
        run_cnt = 0;
      end
    end
    prev_rst = rst;
  end

  task automatic wait_accept(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mul_if.in_ready) got = 1'b1;
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk);
    #1;
    mul_if.in_valid = 1'b0;
    mul_if.in1      = 8'hA5;
    mul_if.in2      = 8'h5A;
  endtask

  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input logic [16:0] exp_out, input int exp_k);
    int runs = 0;
    bit got  = 1'b0;
    @(posedge clk);
    #1;
    mul_if.in_valid  = 1'b1;
    mul_if.in1       = a;
    mul_if.in2       = b;
    mul_if.out_ready = 1'b0;
    wait_accept(nm);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mul_if.out_valid) begin
        got = 1'b1;
      end else begin
        runs++;
        chk({nm, "_ready_low"}, mul_if.in_ready, 0);
      end
    end
    chk({nm, "_valid_seen"}, got, 1);
    chk({nm, "_steps"}, runs, exp_k);
    chk({nm, "_out"}, mul_if.out, exp_out);
    chk({nm, "_overflow"}, mul_if.overflow, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, mul_if.out_valid, 1);
      chk({nm, "_hold_out"}, mul_if.out, exp_out);
    end
    @(posedge clk);
    #1;
    mul_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mul_if.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_ready"}, mul_if.in_ready, 1);
    chk({nm, "_idle_busy"}, mul_if.busy, 0);
  endtask

  initial begin
    int accepted = 0;
    int cyc      = 0;
    rst              = 1'b1;
    mul_if.in_valid  = 1'b0;
    mul_if.in1       = '0;
    mul_if.in2       = '0;
    mul_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    do_op("m13x11", 8'd13, 8'd11, 0, 17'd143, 4);
    do_op("m255x255", 8'd255, 8'd255, 0, 17'd65025, 8);
    do_op("m200x0", 8'd200, 8'd0, 0, 17'd0, 1);
    do_op("m200x1", 8'd200, 8'd1, 0, 17'd200, 1);
    do_op("m7x9_hold", 8'd7, 8'd9, 5, 17'd63, 4);

    // Reset during the third step of 100*200; nothing may come out.
    @(posedge clk);
    #1;
    mul_if.in_valid = 1'b1;
    mul_if.in1      = 8'd100;
    mul_if.in2      = 8'd200;
    wait_accept("rst_mid");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_before", mul_if.busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", mul_if.out_valid, 0);
    chk("rst_mid_busy", mul_if.busy, 0);
    chk("rst_mid_ready", mul_if.in_ready, 1);
    do_op("m3x5", 8'd3, 8'd5, 0, 17'd15, 3);

    // Back-to-back pairs with in_valid and out_ready held high.
    @(posedge clk);
    #1;
    mul_if.out_ready = 1'b1;
    mul_if.in_valid  = 1'b1;
    mul_if.in1       = 8'($urandom_range(0, 255));
    mul_if.in2       = 8'($urandom_range(0, 255));
    while (accepted < 40 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mul_if.in_ready) begin
        accepted++;
        @(posedge clk);
        #1;
        mul_if.in1 = (accepted % 7 == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        mul_if.in2 = (accepted % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      end
    end
    chk("random_accepts", accepted, 40);
    mul_if.in_valid = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || mul_if.busy) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("random_drained", exp_q.size(), 0);
    mul_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
